adc0832_responder: RTL and testbench

// Device-side model of the ADC0832 2-channel 8-bit serial ADC. Decodes CS/CLK/DI

---
 rtl/adc0832_pkg.sv | 36 +++
 rtl/adc0832_edge_sync.sv | 63 ++++++
 rtl/adc0832_responder.sv | 152 +++++++++++++++
 tb/tb_adc0832_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc0832_pkg.sv
// rtl/adc0832_pkg.sv - shared types and channel-mux helper for the ADC0832 responder
package adc0832_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_GET_SGL,
    ST_GET_ODD,
    ST_SETTLE,
    ST_MSB_OUT,
    ST_LSB_OUT,
    ST_DONE
  } state_e;

  localparam logic SGL_SINGLE = 1'b1;
  localparam logic ODD_CH1    = 1'b1;

  // Differential modes subtract in 9 bits so the borrow flags a negative result.
  function automatic logic [7:0] mux_sel(input logic [1:0] cfg, input logic [7:0] ch0,
                                         input logic [7:0] ch1, input logic clamp);
    logic [8:0] diff;
    if (cfg[1] == SGL_SINGLE) begin
      return (cfg[0] == ODD_CH1) ? ch1 : ch0;
    end
    if (cfg[0] == ODD_CH1) begin
      diff = {1'b0, ch1} - {1'b0, ch0};
    end else begin
      diff = {1'b0, ch0} - {1'b0, ch1};
    end
    if (clamp && diff[8]) begin
      return 8'h00;
    end
    return diff[7:0];
  endfunction

endpackage

// File: rtl/adc0832_edge_sync.sv
// rtl/adc0832_edge_sync.sv - input synchronisers and serial-clock edge detect
// SYNC_STAGES = 0 passes the pins straight through for a same-clock master.
module adc0832_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sclk,
  input  logic di,
  output logic cs_s,
  output logic di_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic sclk_s;
  logic sclk_prev_q;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign cs_s   = cs;
    assign sclk_s = sclk;
    assign di_s   = di;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] di_q;

    // cs resets deselected so a held-low pin still needs a full sync delay.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cs_q   <= '1;
        sclk_q <= '0;
        di_q   <= '0;
      end else begin
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
          cs_q[i]   <= cs_q[i-1];
          sclk_q[i] <= sclk_q[i-1];
          di_q[i]   <= di_q[i-1];
        end
        cs_q[0]   <= cs;
        sclk_q[0] <= sclk;
        di_q[0]   <= di;
      end
    end

    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign di_s   = di_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

endmodule

// File: rtl/adc0832_responder.sv
// rtl/adc0832_responder.sv - device-side ADC0832 model: frame decode and DO shifter
// Returns the latched sample MSB-first after a leading zero, then bits 1..7 LSB-first.
module adc0832_responder
  import adc0832_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIFF_CLAMP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       clk_0832,
  input  logic       DI,
  output logic       D0832,
  output logic       D0832_oe,
  input  logic [7:0] ch0_val,
  input  logic [7:0] ch1_val,
  output logic       conv_done,
  output logic       conv_abort,
  output logic [1:0] mux_cfg,
  output logic [7:0] sample_q
);

  logic       cs_s;
  logic       di_s;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       fall_now;
  logic       next_bit;
  state_e     state_q;
  logic       sgl_q;
  logic [2:0] idx_q;
  logic       d_q;
  logic       oe_q;
  logic       done_q;
  logic       abort_q;
  logic [1:0] cfg_q;

  adc0832_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .sclk     (clk_0832),
    .di       (DI),
    .cs_s     (cs_s),
    .di_s     (di_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  // A deselect in the same cycle as an edge takes priority; the edge is dropped.
  assign fall_now = sclk_fall & ~cs_s;

  always_comb begin
    next_bit = d_q;
    case (state_q)
      ST_SETTLE, ST_DONE:     next_bit = 1'b0;
      ST_MSB_OUT, ST_LSB_OUT: next_bit = sample_q[idx_q];
      default:                next_bit = d_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sgl_q    <= 1'b0;
      idx_q    <= 3'd0;
      d_q      <= 1'b0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      cfg_q    <= 2'b00;
      sample_q <= 8'h00;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (cs_s) begin
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
        d_q     <= 1'b0;
        abort_q <= (state_q inside {ST_GET_SGL, ST_GET_ODD, ST_SETTLE, ST_MSB_OUT, ST_LSB_OUT});
      end else begin
        if (fall_now) begin
          d_q <= next_bit;
        end
        case (state_q)
          ST_IDLE: state_q <= ST_WAIT_START;
          ST_WAIT_START: begin
            if (sclk_rise && di_s) begin
              state_q <= ST_GET_SGL;
            end
          end
          ST_GET_SGL: begin
            if (sclk_rise) begin
              sgl_q   <= di_s;
              state_q <= ST_GET_ODD;
            end
          end
          ST_GET_ODD: begin
            if (sclk_rise) begin
              cfg_q    <= {sgl_q, di_s};
              sample_q <= mux_sel({sgl_q, di_s}, ch0_val, ch1_val, DIFF_CLAMP != 0);
              state_q  <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (fall_now) begin
              oe_q    <= 1'b1;
              idx_q   <= 3'd7;
              state_q <= ST_MSB_OUT;
            end
          end
          ST_MSB_OUT: begin
            if (fall_now) begin
              if (idx_q == 3'd0) begin
                idx_q   <= 3'd1;
                state_q <= ST_LSB_OUT;
              end else begin
                idx_q <= idx_q - 3'd1;
              end
            end
          end
          ST_LSB_OUT: begin
            if (fall_now) begin
              if (idx_q == 3'd7) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end
          ST_DONE: begin
            if (fall_now) begin
              oe_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign D0832      = fall_now ? next_bit : d_q;
  assign D0832_oe   = oe_q & ~cs_s;
  assign conv_done  = done_q;
  assign conv_abort = abort_q;
  assign mux_cfg    = cfg_q;

endmodule

// File: tb/tb_adc0832_responder.sv
// tb/tb_adc0832_responder.sv - frame-level bench for adc0832_responder
// Three instances share the serial bus: synced/clamped, synced/wrapping, unsynced.
module tb_adc0832_responder;

  typedef struct {
    string      name;
    int         pre;
    logic       sgl;
    logic       odd;
    logic [7:0] c0;
    logic [7:0] c1;
    int         sel;
    int         h;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
    logic [1:0] cfg;
    int         sel;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1;
  logic sclk = 1'b0;
  logic di = 1'b0;
  logic [7:0] ch0 = 8'h00;
  logic [7:0] ch1 = 8'h00;

  logic       do_a, oe_a, done_a, abort_a;
  logic [1:0] cfg_a;
  logic [7:0] samp_a;
  logic       do_b, oe_b, done_b, abort_b;
  logic [1:0] cfg_b;
  logic [7:0] samp_b;
  logic       do_c, oe_c, done_c, abort_c;
  logic [1:0] cfg_c;
  logic [7:0] samp_c;

  int checks = 0;
  int errors = 0;
  int done_cnt[3];
  int abort_cnt[3];
  logic samp_d[0:40];
  logic samp_oe[0:40];
  sb_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  adc0832_responder #(.SYNC_STAGES(2), .DIFF_CLAMP(1)) u_dut (
    .clk(clk), .rst(rst), .cs(cs), .clk_0832(sclk), .DI(di),
    .D0832(do_a), .D0832_oe(oe_a), .ch0_val(ch0), .ch1_val(ch1),
    .conv_done(done_a), .conv_abort(abort_a), .mux_cfg(cfg_a), .sample_q(samp_a));

  adc0832_responder #(.SYNC_STAGES(2), .DIFF_CLAMP(0)) u_wrap (
    .clk(clk), .rst(rst), .cs(cs), .clk_0832(sclk), .DI(di),
    .D0832(do_b), .D0832_oe(oe_b), .ch0_val(ch0), .ch1_val(ch1),
    .conv_done(done_b), .conv_abort(abort_b), .mux_cfg(cfg_b), .sample_q(samp_b));

  adc0832_responder #(.SYNC_STAGES(0), .DIFF_CLAMP(1)) u_fast (
    .clk(clk), .rst(rst), .cs(cs), .clk_0832(sclk), .DI(di),
    .D0832(do_c), .D0832_oe(oe_c), .ch0_val(ch0), .ch1_val(ch1),
    .conv_done(done_c), .conv_abort(abort_c), .mux_cfg(cfg_c), .sample_q(samp_c));

  always @(posedge clk) begin
    if (done_a)  done_cnt[0]  <= done_cnt[0] + 1;
    if (done_b)  done_cnt[1]  <= done_cnt[1] + 1;
    if (done_c)  done_cnt[2]  <= done_cnt[2] + 1;
    if (abort_a) abort_cnt[0] <= abort_cnt[0] + 1;
    if (abort_b) abort_cnt[1] <= abort_cnt[1] + 1;
    if (abort_c) abort_cnt[2] <= abort_cnt[2] + 1;
  end

  function automatic logic out_do(input int s);
    case (s)
      0:       return do_a;
      1:       return do_b;
      default: return do_c;
    endcase
  endfunction

  function automatic logic out_oe(input int s);
    case (s)
      0:       return oe_a;
      1:       return oe_b;
      default: return oe_c;
    endcase
  endfunction

  function automatic logic [1:0] out_cfg(input int s);
    case (s)
      0:       return cfg_a;
      1:       return cfg_b;
      default: return cfg_c;
    endcase
  endfunction

  function automatic logic [7:0] out_samp(input int s);
    case (s)
      0:       return samp_a;
      1:       return samp_b;
      default: return samp_c;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    di = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // One iteration per sclk period; samp_d[g] is DO as seen after g falls.
  task automatic run_frame(input int pre, input logic sgl, input logic odd, input int h,
                           input int sel, input int n, input int chg_at, input logic [7:0] chg_val);
    for (int g = 0; g < n; g++) begin
      samp_d[g]  = out_do(sel);
      samp_oe[g] = out_oe(sel);
      if (g == chg_at) ch1 = chg_val;
      if (g < pre) di = 1'b0;
      else if (g == pre) di = 1'b1;
      else if (g == pre + 1) di = sgl;
      else if (g == pre + 2) di = odd;
      else di = 1'b0;
      sclk = 1'b1;
      repeat (h) @(negedge clk);
      sclk = 1'b0;
      repeat (h) @(negedge clk);
    end
    samp_d[n]  = out_do(sel);
    samp_oe[n] = out_oe(sel);
  endtask

  task automatic apply_vec(input vec_t v, input int chg_at, input logic [7:0] chg_val);
    sb_t e;
    logic [7:0] msb;
    logic [7:0] lsb;
    int d0, a0;
    ch0 = v.c0;
    ch1 = v.c1;
    sb.push_back('{v.name, v.exp, {v.sgl, v.odd}, v.sel});
    d0 = done_cnt[v.sel];
    a0 = abort_cnt[v.sel];
    cs_low();
    run_frame(v.pre, v.sgl, v.odd, v.h, v.sel, v.pre + 19, chg_at, chg_val);
    cs_high();
    e = sb.pop_front();
    lsb = 8'h00;
    for (int i = 0; i < 8; i++) msb[7 - i] = samp_d[v.pre + 4 + i];
    for (int i = 1; i < 8; i++) lsb[i] = samp_d[v.pre + 11 + i];
    chk({e.name, " msb_first"}, 32'(msb), 32'(e.exp));
    chk({e.name, " lsb_first"}, 32'(lsb[7:1]), 32'(e.exp[7:1]));
    chk({e.name, " lead_zero"}, 32'(samp_d[v.pre + 3]), 32'd0);
    chk({e.name, " oe_on"}, 32'(samp_oe[v.pre + 3]), 32'd1);
    chk({e.name, " oe_off_after_done"}, 32'(samp_oe[v.pre + 19]), 32'd0);
    chk({e.name, " mux_cfg"}, 32'(out_cfg(e.sel)), 32'(e.cfg));
    chk({e.name, " sample_q"}, 32'(out_samp(e.sel)), 32'(e.exp));
    chk({e.name, " conv_done_count"}, 32'(done_cnt[e.sel] - d0), 32'd1);
    chk({e.name, " no_abort"}, 32'(abort_cnt[e.sel] - a0), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, d0;
    vecs[0] = '{"ch1_single",   0, 1'b1, 1'b1, 8'hA5, 8'h3C, 0, 4, 8'h3C};
    vecs[1] = '{"diff00_clamp", 0, 1'b0, 1'b0, 8'h80, 8'h90, 0, 4, 8'h00};
    vecs[2] = '{"diff01",       0, 1'b0, 1'b1, 8'h80, 8'h90, 0, 4, 8'h10};
    vecs[3] = '{"diff00_wrap",  0, 1'b0, 1'b0, 8'h80, 8'h90, 1, 4, 8'hF0};
    vecs[4] = '{"lead_zeros",   2, 1'b1, 1'b0, 8'h5A, 8'h11, 0, 4, 8'h5A};
    vecs[5] = '{"nosync_ch1",   0, 1'b1, 1'b1, 8'h00, 8'hC3, 2, 1, 8'hC3};
    vecs[6] = '{"nosync_ch0",   0, 1'b1, 1'b0, 8'hA5, 8'h3C, 2, 1, 8'hA5};

    repeat (3) @(negedge clk);
    chk("reset D0832", 32'(do_a), 32'd0);
    chk("reset oe", 32'(oe_a), 32'd0);
    chk("reset conv_done", 32'(done_a), 32'd0);
    chk("reset conv_abort", 32'(abort_a), 32'd0);
    chk("reset mux_cfg", 32'(cfg_a), 32'd0);
    chk("reset sample_q", 32'(samp_a), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], -1, 8'h00);

    // Deselect after the fifth MSB-first bit.
    ch0 = 8'h00;
    ch1 = 8'h3C;
    a0 = abort_cnt[0];
    d0 = done_cnt[0];
    cs_low();
    run_frame(0, 1'b1, 1'b1, 4, 0, 8, -1, 8'h00);
    chk("abort bit3_before_cs", 32'(samp_d[8]), 32'd1);
    chk("abort oe_before_cs", 32'(samp_oe[8]), 32'd1);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort oe_released", 32'(oe_a), 32'd0);
    repeat (6) @(negedge clk);
    chk("abort pulse_count", 32'(abort_cnt[0] - a0), 32'd1);
    chk("abort no_done", 32'(done_cnt[0] - d0), 32'd0);
    apply_vec('{"after_abort", 0, 1'b1, 1'b1, 8'h00, 8'hC3, 0, 4, 8'hC3}, -1, 8'h00);

    // Reset in the middle of MSB_OUT.
    ch1 = 8'h3C;
    a0 = abort_cnt[0];
    cs_low();
    run_frame(0, 1'b1, 1'b1, 4, 0, 7, -1, 8'h00);
    chk("midrst oe_before", 32'(samp_oe[7]), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst D0832", 32'(do_a), 32'd0);
    chk("midrst oe", 32'(oe_a), 32'd0);
    chk("midrst mux_cfg", 32'(cfg_a), 32'd0);
    chk("midrst sample_q", 32'(samp_a), 32'd0);
    @(negedge clk);
    cs = 1'b1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst no_abort", 32'(abort_cnt[0] - a0), 32'd0);

    // Channel value moves after the ODD rise; the latched sample must not.
    apply_vec('{"ch1_late_change", 0, 1'b1, 1'b1, 8'h00, 8'h3C, 0, 4, 8'h3C}, 3, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
